// File: rtl/dlatch_arb_pkg.sv
// Shared types for the D-latch write arbiter: FSM states, bank owner encoding
// and the round-robin winner selection.
package dlatch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        OWNER_A,
        OWNER_B
    } owner_t;

    localparam owner_t OWNER_RESET = OWNER_B;
    localparam int     CNT_W       = 4;

    // A tie goes to whichever requester was not served last.
    function automatic owner_t pick_winner(input owner_t last, input logic req_a,
                                           input logic req_b);
        if (req_a && req_b) begin
            return (last == OWNER_A) ? OWNER_B : OWNER_A;
        end
        return req_a ? OWNER_A : OWNER_B;
    endfunction

endpackage

// File: rtl/dlatch_write_arbiter_if.sv
// Requester/latch-bank signal bundle for dlatch_write_arbiter. The latch
// readback and error flag exist only when DLATCH_ARB_CHECK_EN is defined.
interface dlatch_write_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             reqA;
    logic [WIDTH-1:0] dataA;
    logic             reqB;
    logic [WIDTH-1:0] dataB;
    logic             gntA;
    logic             gntB;
    logic             doneA;
    logic             doneB;
    logic [WIDTH-1:0] latchD;
    logic             latchEn;
    logic             busy;
`ifdef DLATCH_ARB_CHECK_EN
    logic [WIDTH-1:0] latchQ;
    logic [WIDTH-1:0] latchQinv;
    logic             err;

    modport master (
        output reqA, dataA, reqB, dataB, latchQ, latchQinv,
        input  gntA, gntB, doneA, doneB, latchD, latchEn, busy, err
    );
    modport slave (
        input  reqA, dataA, reqB, dataB, latchQ, latchQinv,
        output gntA, gntB, doneA, doneB, latchD, latchEn, busy, err
    );
`else
    modport master (
        output reqA, dataA, reqB, dataB,
        input  gntA, gntB, doneA, doneB, latchD, latchEn, busy
    );
    modport slave (
        input  reqA, dataA, reqB, dataB,
        output gntA, gntB, doneA, doneB, latchD, latchEn, busy
    );
`endif
endinterface

// File: rtl/dlatch_hold_counter.sv
// Loadable 4-bit down-counter that times the latch enable window.
module dlatch_hold_counter
    import dlatch_arb_pkg::*;
(
    input  logic             clock,
    input  logic             resetN,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, regardless of block ordering.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dlatch_write_arbiter.sv
// Round-robin setup/enable/hold sequencer sharing one gated D-latch bank
// between two requesters. Define DLATCH_ARB_CHECK_EN for latch readback checking.
module dlatch_write_arbiter
    import dlatch_arb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input logic                   clock,
    input logic                   resetN,
    dlatch_write_arbiter_if.slave bus
);
    arb_state_t       state, state_next;
    owner_t           owner, owner_next;
    logic [WIDTH-1:0] latch_d, data_next;
    logic             grant;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             gnt_a, gnt_b, done_a, done_b, latch_en, busy;

    dlatch_hold_counter u_hold (
        .clock      (clock),
        .resetN     (resetN),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (CNT_W'(HOLD_CYCLES - 1)),
        .zero       (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        owner_next = owner;
        data_next  = latch_d;
        grant      = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.reqA || bus.reqB) begin
                    owner_next = pick_winner(owner, bus.reqA, bus.reqB);
                    grant      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cnt_load   = 1'b1;
                state_next = ENABLE;
            end
            ENABLE: begin
                if (cnt_zero) begin
                    state_next = RELEASE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RELEASE: begin
                // Only the non-owner can take over directly; the finisher waits.
                state_next = IDLE;
                if ((owner == OWNER_A) ? bus.reqB : bus.reqA) begin
                    owner_next = (owner == OWNER_A) ? OWNER_B : OWNER_A;
                    grant      = 1'b1;
                    state_next = SETUP;
                end
            end
        endcase
        if (grant) begin
            data_next = (owner_next == OWNER_A) ? bus.dataA : bus.dataB;
        end
    end

    // Outputs are decoded from the next state so they leave flops aligned with it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            owner    <= OWNER_RESET;
            latch_d  <= '0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            latch_en <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            latch_d  <= data_next;
            gnt_a    <= (state_next != IDLE) && (owner_next == OWNER_A);
            gnt_b    <= (state_next != IDLE) && (owner_next == OWNER_B);
            done_a   <= (state_next == RELEASE) && (owner_next == OWNER_A);
            done_b   <= (state_next == RELEASE) && (owner_next == OWNER_B);
            latch_en <= (state_next == ENABLE);
            busy     <= (state_next != IDLE);
        end
    end

    assign bus.gntA    = gnt_a;
    assign bus.gntB    = gnt_b;
    assign bus.doneA   = done_a;
    assign bus.doneB   = done_b;
    assign bus.latchD  = latch_d;
    assign bus.latchEn = latch_en;
    assign bus.busy    = busy;

`ifdef DLATCH_ARB_CHECK_EN
    logic err;

    // Sticky: a bad readback in any RELEASE is held until reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            err <= 1'b0;
        end else if ((state == RELEASE) &&
                     ((bus.latchQ != latch_d) || (bus.latchQinv != ~latch_d))) begin
            err <= 1'b1;
        end
    end

    assign bus.err = err;
`endif

endmodule

// File: doc/dlatch_write_arbiter.md
# dlatch_write_arbiter

Sequencing controller that shares one WIDTH-bit gated D-latch bank, i.e. WIDTH instances of the FlipFlopDLin-style cell, between two requesters, A and B. It owns the bank's data and enable (`clock` input) lines. Each write is a setup / enable / hold sequence, so no latch sees data change while its enable is high. Round-robin arbitration decides simultaneous requests; a one-cycle done pulse closes each transaction.

## Interface
Parameters:
- `WIDTH`, 4: latch bank width in bits.
- `HOLD_CYCLES`, 2: cycles `latchEn` stays high per write; legal range 1..15.

Ports:
- `clock`  input  1  sole clock, rising edge.
- `resetN`  input  1  asynchronous, active-low reset.
- `reqA`  input  1  requester A write request.
- `dataA`  input  WIDTH  requester A write data.
- `reqB`  input  1  requester B write request.
- `dataB`  input  WIDTH  requester B write data.
- `gntA`  output  1  high while A owns the bank.
- `gntB`  output  1  high while B owns the bank.
- `doneA`  output  1  one-cycle pulse when A's write completes.
- `doneB`  output  1  one-cycle pulse when B's write completes.
- `latchD`  output  WIDTH  data to the latch bank `i` inputs.
- `latchEn`  output  1  enable to the latch bank `clock` inputs.
- `busy`  output  1  state is not IDLE.

## Operation
- States: IDLE, SETUP, ENABLE, RELEASE. All outputs are registered and Moore-decoded from state plus owner.
- IDLE: if any `req` is high, grant a winner, capture its data into `latchD`, and go to SETUP.
- Arbitration: single request wins outright. If both request, the requester not served last wins. The last-served bit resets to B, so A wins the first tie.
- Data is sampled only at the grant edge. The requester's data may change afterwards.
- SETUP, 1 cycle: `latchD` is valid and `latchEn`=0. Load the hold counter with HOLD_CYCLES−1. Go to ENABLE.
- ENABLE, HOLD_CYCLES cycles: `latchEn`=1 and the counter decrements. Leave when the counter is 0.
- RELEASE, 1 cycle: `latchEn`=0, `latchD` held, and the owner's `done` is high.
- From RELEASE: if the non-owner's `req` is high, grant it directly (next state SETUP). Otherwise go to IDLE. The finishing owner's `req` is ignored in RELEASE.
- A requester deasserts `req` in the cycle after its `done`. If `req` is still high then, it is treated as a new request.
- `req` dropped after grant does not abort the write; `done` still pulses.
- `gntX` is high in SETUP, ENABLE and RELEASE when X owns the bank.
- Reset values: state IDLE; `gntA`, `gntB`, `doneA`, `doneB`, `latchEn`, `busy` = 0; `latchD` = 0; last-served = B; counter = 0.
- Reset asserted mid-write drops `latchEn` immediately (asynchronous). The interrupted write gets no `done`.

## Timing
- Grant latency: `req` seen at edge n → `gnt`, `busy`, `latchD` valid after edge n.
- Transaction length: HOLD_CYCLES+2 cycles from grant to the end of RELEASE.
- `latchEn` rises one cycle after `latchD` settles and falls one cycle before `latchD` may change.
- Back-to-back A→B: B's SETUP starts the cycle after A's RELEASE, so throughput is one write per HOLD_CYCLES+2 cycles.
- `latchEn` is glitch-free: it is a flop output and is never combinationally decoded.

## Configuration
- `DLATCH_ARB_CHECK_EN` defined: adds inputs `latchQ`  input  WIDTH and `latchQinv`  input  WIDTH, and output `err`  output  1.
  - In RELEASE, if `latchQ` != `latchD` or `latchQinv` != ~`latchD`, the sticky `err` sets.
  - `err` clears only on reset; its reset value is 0.
- `DLATCH_ARB_CHECK_EN` undefined: these ports and this logic are absent, and behaviour is otherwise identical.

## Structure
- Package `dlatch_arb_pkg` holds:
  - `arb_state_t` (IDLE, SETUP, ENABLE, RELEASE);
  - `owner_t` (OWNER_A, OWNER_B);
  - `OWNER_RESET` = OWNER_B.
- One sub-module, `dlatch_hold_counter`: loadable 4-bit down-counter with load, decrement and zero-flag.
- Fanout of `clock`, `resetN` and the captured data goes through the existing `split` cell. Every internal wire has exactly one driver and one consumer.

## Test plan
All scenarios use WIDTH=4 and HOLD_CYCLES=2.
- Single write: `reqA`=1, `dataA`=4'hA at edge 0 → `gntA`=1 and `latchD`=4'hA after edge 0; `latchEn`=1 for exactly 2 cycles starting one cycle later; `doneA` pulses 1 cycle; total 4 cycles.
- Tie after reset: `reqA`, `reqB` both high, `dataA`=4'h3, `dataB`=4'hC → A served first (`latchD`=4'h3); B granted the cycle after `doneA` with `latchD`=4'hC, with no IDLE cycle between.
- Fairness: both requests held continuously for 4 transactions → grants alternate A, B, A, B.
- Data capture: change `dataA` from 4'h5 to 4'hF one cycle after grant → `latchD` stays 4'h5 through RELEASE.
- Reset mid-write: drop `resetN` in the 2nd ENABLE cycle → `latchEn`, `gntA`, `busy` go to 0 immediately; no `doneA`; `latchD`=0.
- With `DLATCH_ARB_CHECK_EN`: drive `latchQ`=4'h0 during a write of 4'h6 → `err`=1 after RELEASE and it stays 1 until reset.
